// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared constants for the two-street traffic-light controller:
//               state encodings S0-S3 and the 2-bit light codes.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    // State encodings, S[1:0]
    localparam logic [1:0] S0 = 2'b00;  // A green,  B red
    localparam logic [1:0] S1 = 2'b01;  // A yellow, B red
    localparam logic [1:0] S2 = 2'b10;  // A red,    B green
    localparam logic [1:0] S3 = 2'b11;  // A red,    B yellow

    // Light codes; 2'b11 is never driven
    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

endpackage : tl_pkg
`default_nettype wire

// File: rtl/tl_dff_r.sv
`default_nettype none
// ============================================================================
// Module      : tl_dff_r
// Description : 1-bit D flip-flop, rising-edge clock, asynchronous
//               active-high reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_dff_r (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Capture d on every rising edge; reset clears q without waiting for clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule : tl_dff_r
`default_nettype wire

// File: rtl/tl_cntr_struct.sv
`default_nettype none
// ============================================================================
// Module      : tl_cntr_struct
// Description : Structural Moore FSM traffic-light controller for two streets.
//               Two tl_dff_r instances hold S[1:0]; next-state and light
//               outputs are plain gate equations of the state (and sensors
//               for next-state only), so the lights never see Ta/Tb directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_cntr_struct
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,   // active-high despite the name
    input  logic       Ta,
    input  logic       Tb,
    output logic [1:0] La,
    output logic [1:0] Lb
);

    logic [1:0] w_state;
    logic [1:0] w_next;

    // Next-state logic. S0 holds while Ta is present, S2 holds while Tb is
    // present; S1 and S3 always advance. Ta only matters when S=00 and Tb
    // only when S=10, which falls out of the product terms directly.
    assign w_next[1] = w_state[1] ^ w_state[0];
    assign w_next[0] = (~w_state[1] & ~w_state[0] & ~Ta)
                     | ( w_state[1] & ~w_state[0] & ~Tb);

    // State register, one flip-flop per state bit; reset lands on S0 (00)
    generate
        for (genvar i = 0; i < 2; i++) begin : g_state_bit
            tl_dff_r u_dff (
                .clk (clk),
                .rst (reset_n),
                .d   (w_next[i]),
                .q   (w_state[i])
            );
        end
    endgenerate

    // Output logic, a function of state only
    assign La[1] =  w_state[1];
    assign La[0] = ~w_state[1] & w_state[0];
    assign Lb[1] = ~w_state[1];
    assign Lb[0] =  w_state[1] & w_state[0];

endmodule : tl_cntr_struct
`default_nettype wire

// File: tb/tb_tl_cntr_struct.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_cntr_struct
// Description : Directed self-checking bench for tl_cntr_struct.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_cntr_struct;
    import tl_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       Ta;
    logic       Tb;
    logic [1:0] La;
    logic [1:0] Lb;

    int vectors     = 0;
    int miscompares = 0;

    tl_cntr_struct dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tb      (Tb),
        .La      (La),
        .Lb      (Lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare both lights against expected codes, then check legality
    task automatic check(input string tag, input logic [1:0] la_exp,
                         input logic [1:0] lb_exp);
        vectors++;
        assert (La === la_exp) else begin
            miscompares++;
            $error("FAIL %s La: observed %b expected %b", tag, La, la_exp);
        end
        vectors++;
        assert (Lb === lb_exp) else begin
            miscompares++;
            $error("FAIL %s Lb: observed %b expected %b", tag, Lb, lb_exp);
        end
        vectors++;
        assert ((La !== 2'b11) && (Lb !== 2'b11) && (La[1] || Lb[1])) else begin
            miscompares++;
            $error("FAIL %s legality: observed La=%b Lb=%b expected one RED, no 11",
                   tag, La, Lb);
        end
    endtask

    // Drive sensors at the falling edge, then sample just after the rising edge
    task automatic step(input logic ta, input logic tb);
        @(negedge clk);
        Ta = ta;
        Tb = tb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        Ta      = 1'b1;
        Tb      = 1'b0;

        // Reset takes effect before any clock edge (first edge at t=5)
        #1 reset_n = 1'b1;
        #1 check("reset_async", GREEN, RED);

        // Reset held across an edge keeps S0
        @(posedge clk); #1;
        check("reset_held", GREEN, RED);

        // Release and dwell with Ta=1 for three edges
        @(negedge clk);
        reset_n = 1'b0;
        step(1'b1, 1'b0); check("dwell_1", GREEN, RED);
        step(1'b1, 1'b0); check("dwell_2", GREEN, RED);
        step(1'b1, 1'b0); check("dwell_3", GREEN, RED);

        // Full cycle
        step(1'b0, 1'b1); check("cycle_s1", YELLOW, RED);
        step(1'b0, 1'b1); check("cycle_s2", RED, GREEN);
        step(1'b0, 1'b1); check("cycle_s2_hold", RED, GREEN);
        step(1'b0, 1'b0); check("cycle_s3", RED, YELLOW);
        step(1'b1, 1'b0); check("cycle_s0", GREEN, RED);

        // Ignored inputs: Tb toggles in S0/S1, Ta toggles in S2/S3
        step(1'b1, 1'b1); check("ign_s0_tb1", GREEN, RED);
        step(1'b1, 1'b0); check("ign_s0_tb0", GREEN, RED);
        step(1'b0, 1'b1); check("ign_to_s1", YELLOW, RED);
        step(1'b1, 1'b0); check("ign_s1_to_s2", RED, GREEN);
        step(1'b0, 1'b1); check("ign_s2_ta0", RED, GREEN);
        step(1'b1, 1'b1); check("ign_s2_ta1", RED, GREEN);
        step(1'b1, 1'b0); check("ign_to_s3", RED, YELLOW);
        step(1'b0, 1'b1); check("ign_s3_to_s0", GREEN, RED);

        // Drive back to S2, then reset between edges
        step(1'b0, 1'b1); check("mid_s1", YELLOW, RED);
        step(1'b0, 1'b1); check("mid_s2", RED, GREEN);
        #2 reset_n = 1'b1;
        #1 check("mid_reset_async", GREEN, RED);
        @(posedge clk); #1;
        check("mid_reset_held", GREEN, RED);

        // First transition after release happens on the next edge
        @(negedge clk);
        reset_n = 1'b0;
        Ta      = 1'b0;
        @(posedge clk); #1;
        check("post_reset_s1", YELLOW, RED);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tl_cntr_struct
`default_nettype wire

// File: doc/tl_cntr_struct.md
TL_CNTR_STRUCT -- requirements
Module: tl_cntr_struct

Interface
REQ-001 The clocking and reset scheme SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 Port list, clock and reset first:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-high; the port name follows codebase convention.
- Ta  input  1  traffic sensor, street A; 1 = traffic present.
- Tb  input  1  traffic sensor, street B; 1 = traffic present.
- La  output  2  light, street A.
- Lb  output  2  light, street B.
REQ-003 Light code SHALL be: 00 = GREEN, 01 = YELLOW, 10 = RED; 11 is never driven.

Function
REQ-004 The block SHALL be a Moore FSM with 2-bit state S[1:0] and four states:
- S0 = 00: La GREEN, Lb RED.
- S1 = 01: La YELLOW, Lb RED.
- S2 = 10: La RED, Lb GREEN.
- S3 = 11: La RED, Lb YELLOW.
REQ-005 Transitions SHALL occur on the rising clk edge:
- S0: stays in S0 while Ta=1; goes to S1 when Ta=0.
- S1: goes to S2 unconditionally.
- S2: stays in S2 while Tb=1; goes to S3 when Tb=0.
- S3: goes to S0 unconditionally.
REQ-006 Next-state equations:
- S1' = S1 XOR S0.
- S0' = (~S1 & ~S0 & ~Ta) | (S1 & ~S0 & ~Tb).
REQ-007 Output equations:
- La[1] = S1; La[0] = ~S1 & S0.
- Lb[1] = ~S1; Lb[0] = S1 & S0.
REQ-008 Outputs SHALL depend on state only, with no combinational path from Ta or Tb to La or Lb.
REQ-009 Ta is ignored outside S0, and Tb is ignored outside S2.
REQ-010 A sensor change takes effect at the first rising edge that samples it; there is no input synchronizer and no minimum-dwell timer.
REQ-011 When Ta and Tb change together, only the input relevant to the current state SHALL matter.
REQ-012 All four state encodings SHALL be legal, so no recovery logic is needed.

Reset
REQ-013 While reset_n=1, state SHALL be forced to S0 immediately, without waiting for a clock edge, giving La=00 and Lb=10.
REQ-014 Reset asserted mid-cycle in any state SHALL return the FSM to S0 asynchronously.
REQ-015 After reset is released, the first transition SHALL evaluate on the next rising clk edge.

Structure
REQ-016 Implementation SHALL be structural, with three parts:
- a 2-bit state register;
- gate-level next-state logic;
- gate-level output logic.
REQ-017 There SHALL be one sub-module, tl_dff_r: a 1-bit D flip-flop with asynchronous active-high reset to 0, instantiated twice.
REQ-018 A shared package tl_pkg SHALL hold the state encodings S0–S3 and the light constants GREEN, YELLOW and RED.

Verification
REQ-019 Reset: assert reset_n=1 with Ta=1 and Tb=0 -> La=00 and Lb=10 at once, with no clk edge required.
REQ-020 Dwell: release reset, hold Ta=1 for 3 edges -> state stays S0 (La=00, Lb=10).
REQ-021 Full cycle, with Ta dropped to 0 and edges counted from that point:
- edge 1: La=01, Lb=10;
- edge 2: La=10, Lb=00 (held while Tb=1);
- after Tb=0, next edge: La=10, Lb=01;
- following edge: La=00, Lb=10.
REQ-022 Ignored inputs: toggle Tb during S0/S1 and Ta during S2/S3 -> the sequence is unchanged from REQ-021.
REQ-023 Mid-operation reset: assert reset_n=1 in S2 between clock edges -> La=00 and Lb=10 immediately.
REQ-024 Output legality: across all runs, La and Lb never equal 11, and never show GREEN or YELLOW on both streets at once.
